// File: rtl/instruction_fetcher_pkg.sv
// Shared widths, cache sizing default and fetch FSM encoding for the instruction fetcher.
package instruction_fetcher_pkg;

  localparam int unsigned INST_WID         = 32;
  localparam int unsigned ADDR_WID         = 32;
  localparam int unsigned ICACHE_IDX_W_DEF = 4;

  typedef enum logic {
    StIdle  = 1'b0,
    StFetch = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetcher_if.sv
// Fetch-side bus: memory-controller request/response plus the fetch->decode issue port.
interface instruction_fetcher_if
  import instruction_fetcher_pkg::*;
;

  logic                mc_en;
  logic [ADDR_WID-1:0] mc_pc;
  logic                mc_done;
  logic [INST_WID-1:0] mc_data;
  logic                inst_rdy;
  logic [INST_WID-1:0] inst;
  logic [ADDR_WID-1:0] inst_pc;

  modport master (
    output mc_en,
    output mc_pc,
    input  mc_done,
    input  mc_data,
    output inst_rdy,
    output inst,
    output inst_pc
  );

  modport slave (
    input  mc_en,
    input  mc_pc,
    output mc_done,
    output mc_data,
    input  inst_rdy,
    input  inst,
    input  inst_pc
  );

endinterface

// File: rtl/instruction_fetcher_icache_direct.sv
// Direct-mapped one-word-per-line instruction cache: combinational lookup, synchronous fill.
module instruction_fetcher_icache_direct
  import instruction_fetcher_pkg::*;
#(
  parameter int unsigned IdxW = ICACHE_IDX_W_DEF,
  parameter int unsigned TagW = ADDR_WID - ICACHE_IDX_W_DEF - 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IdxW-1:0]     rd_idx,
  input  logic [TagW-1:0]     rd_tag,
  output logic                hit,
  output logic [INST_WID-1:0] rd_data,
  input  logic                wr_en,
  input  logic [IdxW-1:0]     wr_idx,
  input  logic [TagW-1:0]     wr_tag,
  input  logic [INST_WID-1:0] wr_data
);

  localparam int unsigned Entries = 1 << IdxW;

  logic [Entries-1:0]  valid_q;
  logic [TagW-1:0]     tag_q  [Entries];
  logic [INST_WID-1:0] data_q [Entries];

  assign hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data = data_q[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: they are qualified by valid_q.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/instruction_fetcher.sv
// Fetch stage: PC+4 prediction, icache lookup, miss refill from the memory controller,
// stall on backend full and redirect on ROB rollback.
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter int unsigned         ICACHE_IDX_W = ICACHE_IDX_W_DEF,
  parameter logic [ADDR_WID-1:0] RESET_PC     = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  rs_full,
  input  logic                  lsb_full,
  input  logic                  rob_full,
  input  logic                  rob_set_pc_en,
  input  logic [ADDR_WID-1:0]   rob_set_pc,
  instruction_fetcher_if.master bus
);

  localparam int unsigned TagW = ADDR_WID - ICACHE_IDX_W - 2;

  fetch_state_e        state_q, state_d;
  logic [ADDR_WID-1:0] pc_q, pc_d;
  logic                inst_rdy_q, inst_rdy_d;
  logic [INST_WID-1:0] inst_q, inst_d;
  logic [ADDR_WID-1:0] inst_pc_q, inst_pc_d;
  logic                mc_en_q, mc_en_d;
  logic [ADDR_WID-1:0] mc_pc_q, mc_pc_d;

  logic                stall;
  logic                hit;
  logic [INST_WID-1:0] line_data;
  logic                fill_en;

  assign stall = rs_full | lsb_full | rob_full;

  // The fill is kept even when a rollback lands on the same cycle: data is valid for mc_pc.
  assign fill_en = rdy && (state_q == StFetch) && bus.mc_done;

  instruction_fetcher_icache_direct #(
    .IdxW (ICACHE_IDX_W),
    .TagW (TagW)
  ) u_icache (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (pc_q[ICACHE_IDX_W+1:2]),
    .rd_tag  (pc_q[ADDR_WID-1:ICACHE_IDX_W+2]),
    .hit     (hit),
    .rd_data (line_data),
    .wr_en   (fill_en),
    .wr_idx  (mc_pc_q[ICACHE_IDX_W+1:2]),
    .wr_tag  (mc_pc_q[ADDR_WID-1:ICACHE_IDX_W+2]),
    .wr_data (bus.mc_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      inst_rdy_q <= 1'b0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      mc_en_q    <= 1'b0;
      mc_pc_q    <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_rdy_q <= inst_rdy_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      mc_en_q    <= mc_en_d;
      mc_pc_q    <= mc_pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (rob_set_pc_en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  state_d = hit ? StIdle : StFetch;
        StFetch: state_d = bus.mc_done ? StIdle : StFetch;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    pc_d       = pc_q;
    inst_rdy_d = 1'b0;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    mc_en_d    = mc_en_q;
    mc_pc_d    = mc_pc_q;
    if (rob_set_pc_en) begin
      pc_d    = rob_set_pc;
      mc_en_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hit) begin
            if (!stall) begin
              inst_rdy_d = 1'b1;
              inst_d     = line_data;
              inst_pc_d  = pc_q;
              pc_d       = pc_q + 32'd4;
            end
          end else begin
            // Misses start refilling even under stall so the line is ready on release.
            mc_en_d = 1'b1;
            mc_pc_d = pc_q;
          end
        end
        StFetch: begin
          if (bus.mc_done) begin
            mc_en_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mc_en    = mc_en_q;
  assign bus.mc_pc    = mc_pc_q;
  assign bus.inst_rdy = inst_rdy_q;
  assign bus.inst     = inst_q;
  assign bus.inst_pc  = inst_pc_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed plus random bench for instruction_fetcher, checked against an address-level
// stream/cache model and a latency-programmable memory responder.
module tb_instruction_fetcher;
  import instruction_fetcher_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        rs_full = 1'b0;
  logic        lsb_full = 1'b0;
  logic        rob_full = 1'b0;
  logic        rob_set_pc_en = 1'b0;
  logic [31:0] rob_set_pc = '0;

  instruction_fetcher_if bus ();

  instruction_fetcher #(
    .ICACHE_IDX_W (4),
    .RESET_PC     (32'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .rs_full       (rs_full),
    .lsb_full      (lsb_full),
    .rob_full      (rob_full),
    .rob_set_pc_en (rob_set_pc_en),
    .rob_set_pc    (rob_set_pc),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err = 0;
  int unsigned mem_lat = 3;
  int unsigned mem_cnt = 0;
  bit          mem_auto = 1'b1;
  bit          chk_en = 1'b0;
  int          issued = 0;

  // Model: next PC the decoder should see, and which word address each cache line holds.
  logic [31:0] exp_pc = '0;
  bit          m_valid [16];
  logic [31:0] m_addr  [16];

  logic        p_mc_en = 1'b0;
  logic [31:0] p_mc_pc = '0;
  logic        p_inst_rdy = 1'b0;
  logic [31:0] p_inst = '0;
  logic [31:0] p_inst_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  function automatic bit cached(input logic [31:0] a);
    int i;
    i = int'(a[5:2]);
    return m_valid[i] && (m_addr[i] == a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit          rdy_at, rb_at, stall_at, done_at, exp_issue, exp_mc_en;
    logic [31:0] tgt_at;
    if (mem_auto) begin
      bus.mc_done = 1'b0;
      if (rdy) begin
        if (p_mc_en) begin
          mem_cnt++;
          if (mem_cnt >= mem_lat) begin
            bus.mc_done = 1'b1;
            bus.mc_data = mem_word(p_mc_pc);
            mem_cnt     = 0;
          end
        end else begin
          mem_cnt = 0;
        end
      end
    end
    rdy_at    = rdy;
    rb_at     = rob_set_pc_en;
    tgt_at    = rob_set_pc;
    stall_at  = rs_full | lsb_full | rob_full;
    done_at   = bus.mc_done;
    exp_issue = rdy_at && !rb_at && !stall_at && cached(exp_pc);
    if (!rdy_at)      exp_mc_en = p_mc_en;
    else if (rb_at)   exp_mc_en = 1'b0;
    else if (p_mc_en) exp_mc_en = !done_at;
    else              exp_mc_en = !cached(exp_pc);
    @(posedge clk);
    #1;
    if (chk_en) begin
      if (!rdy_at) begin
        check("hold_inst_rdy", bus.inst_rdy, p_inst_rdy);
        check("hold_inst", bus.inst, p_inst);
        check("hold_inst_pc", bus.inst_pc, p_inst_pc);
        check("hold_mc_en", bus.mc_en, p_mc_en);
        check("hold_mc_pc", bus.mc_pc, p_mc_pc);
      end else begin
        check("inst_rdy", bus.inst_rdy, exp_issue);
        if (exp_issue) begin
          check("inst_pc", bus.inst_pc, exp_pc);
          check("inst", bus.inst, mem_word(exp_pc));
        end
        check("mc_en", bus.mc_en, exp_mc_en);
        if (exp_mc_en) check("mc_pc", bus.mc_pc, p_mc_en ? p_mc_pc : exp_pc);
        if (p_mc_en && done_at) begin
          m_valid[int'(p_mc_pc[5:2])] = 1'b1;
          m_addr[int'(p_mc_pc[5:2])]  = p_mc_pc;
        end
        if (rb_at)          exp_pc = tgt_at;
        else if (exp_issue) exp_pc = exp_pc + 32'd4;
      end
    end
    if (bus.inst_rdy) issued++;
    p_mc_en    = bus.mc_en;
    p_mc_pc    = bus.mc_pc;
    p_inst_rdy = bus.inst_rdy;
    p_inst     = bus.inst;
    p_inst_pc  = bus.inst_pc;
  endtask

  task automatic redirect(input logic [31:0] target);
    rob_set_pc_en = 1'b1;
    rob_set_pc    = target;
    tick();
    rob_set_pc_en = 1'b0;
  endtask

  task automatic run_until(input string tag, input logic [31:0] pc, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (bus.inst_rdy && bus.inst_pc == pc) seen = 1'b1;
    end
    check(tag, seen, 1'b1);
  endtask

  initial begin
    bus.mc_done = 1'b0;
    bus.mc_data = '0;
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_addr[i]  = '0;
    end

    // Asynchronous reset: checked before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_inst_rdy", bus.inst_rdy, 1'b0);
    check("rst_inst", bus.inst, 32'h0);
    check("rst_inst_pc", bus.inst_pc, 32'h0);
    check("rst_mc_en", bus.mc_en, 1'b0);
    check("rst_mc_pc", bus.mc_pc, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Cold miss at 0 with 3-cycle memory.
    tick();
    check("t1_req_en", bus.mc_en, 1'b1);
    check("t1_req_pc", bus.mc_pc, 32'h0);
    repeat (3) tick();
    check("t1_done_drop", bus.mc_en, 1'b0);
    tick();
    check("t1_inst_rdy", bus.inst_rdy, 1'b1);
    check("t1_inst", bus.inst, 32'h00000013);
    check("t1_inst_pc", bus.inst_pc, 32'h0);
    tick();
    check("t1_next_req", bus.mc_pc, 32'h4);

    // Preload 0..0xC then stream back-to-back from cache.
    run_until("t2_fill", 32'hC, 60);
    redirect(32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_stream_rdy", bus.inst_rdy, 1'b1);
      check("t2_stream_pc", bus.inst_pc, 32'(i * 4));
      check("t2_no_mc", bus.mc_en, 1'b0);
    end

    // Backend full for 3 cycles mid-stream.
    redirect(32'h0);
    tick();
    rob_full = 1'b1;
    repeat (3) begin
      tick();
      check("t3_stalled", bus.inst_rdy, 1'b0);
    end
    rob_full = 1'b0;
    tick();
    check("t3_resume_rdy", bus.inst_rdy, 1'b1);
    check("t3_resume_pc", bus.inst_pc, 32'h4);

    // Rollback during FETCH, then a stale mc_done in IDLE must not fill.
    mem_auto    = 1'b0;
    bus.mc_done = 1'b0;
    redirect(32'h20);
    tick();
    check("t4_req_en", bus.mc_en, 1'b1);
    check("t4_req_pc", bus.mc_pc, 32'h20);
    tick();
    redirect(32'h100);
    check("t4_cancel", bus.mc_en, 1'b0);
    check("t4_no_issue", bus.inst_rdy, 1'b0);
    bus.mc_done = 1'b1;
    bus.mc_data = 32'hDEADBEEF;
    tick();
    bus.mc_done = 1'b0;
    check("t4_new_req", bus.mc_pc, 32'h100);
    check("t4_new_en", bus.mc_en, 1'b1);
    mem_auto = 1'b1;
    mem_cnt  = 0;
    run_until("t4_issue_100", 32'h100, 30);
    redirect(32'h20);
    tick();
    check("t4_stale_ign", bus.mc_en, 1'b1);
    run_until("t4_issue_20", 32'h20, 30);

    // Aliasing: 0x40 evicts 0x0 from the same line.
    redirect(32'h40);
    tick();
    check("t5_alias_miss", bus.mc_pc, 32'h40);
    run_until("t5_issue_40", 32'h40, 30);
    redirect(32'h0);
    tick();
    check("t5_evicted_en", bus.mc_en, 1'b1);
    check("t5_evicted_pc", bus.mc_pc, 32'h0);

    // Global hold in the middle of a refill.
    rdy = 1'b0;
    repeat (5) tick();
    check("t6_frozen_en", bus.mc_en, 1'b1);
    rdy = 1'b1;
    run_until("t6_resume", 32'h0, 30);

    // Random traffic: stalls, holds, redirects (incl. wrap near 0xFFFFFFFC), varying latency.
    issued = 0;
    for (int n = 0; n < 1500; n++) begin
      rdy      = ($urandom % 10) != 0;
      rs_full  = ($urandom % 12) == 0;
      lsb_full = ($urandom % 12) == 0;
      rob_full = ($urandom % 12) == 0;
      rob_set_pc_en = ($urandom % 25) == 0;
      if (rob_set_pc_en) begin
        if ($urandom % 8 == 0) rob_set_pc = 32'hFFFFFFF8;
        else rob_set_pc = 32'($urandom_range(0, 63)) << 2;
        mem_lat = $urandom_range(1, 4);
      end
      tick();
    end
    rdy = 1'b1;
    {rs_full, lsb_full, rob_full, rob_set_pc_en} = '0;
    check("rand_progress", issued > 50, 1'b1);

    // Asynchronous reset mid-run clears outputs without a clock edge.
    rst = 1'b1;
    #1;
    check("arst_inst_rdy", bus.inst_rdy, 1'b0);
    check("arst_mc_en", bus.mc_en, 1'b0);
    check("arst_mc_pc", bus.mc_pc, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
